// File: rtl/sram_pkg.sv
// Shared constants and types for the sram_rw storage leaf.
package sram_pkg;

    // Default geometry: 16 words of 8 bits.
    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_ADDR_W = 4;
    localparam int DEPTH          = 2 ** DEFAULT_ADDR_W;

    // Operation select encoding on the rw input.
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef logic [DEFAULT_DATA_W-1:0] word_t;

endpackage : sram_pkg

// File: rtl/sram_array.sv
// Storage array: asynchronous clear, one synchronous write port and a
// combinational read port. The read data register lives in the parent.
module sram_array #(
    parameter int DATA_W = sram_pkg::DEFAULT_DATA_W,
    parameter int ADDR_W = sram_pkg::DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int Depth = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [Depth];

    // Clear every word the moment reset asserts; otherwise load the addressed word on a write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // The address always spans the full depth, so the lookup needs no range guard.
    assign rdata_o = mem_q[addr_i];

endmodule : sram_array

// File: rtl/sram_rw.sv
// Single-port synchronous RAM with registered read data and asynchronous
// active-low clear. Decodes rw into a write enable for the array and a
// load enable for the output register.
module sram_rw
    import sram_pkg::*;
#(
    parameter int DATA_W = sram_pkg::DEFAULT_DATA_W,
    parameter int ADDR_W = sram_pkg::DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dataout
);

    logic              writeEn;
    logic              readEn;
    logic [DATA_W-1:0] readData;
    logic [DATA_W-1:0] dataout_q;
    logic [DATA_W-1:0] dataout_d;

    assign writeEn = (rw == RW_WRITE);
    assign readEn  = (rw == RW_READ);

    sram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (writeEn),
        .addr_i  (addr),
        .wdata_i (din),
        .rdata_o (readData)
    );

    // Reads capture the addressed word; writes leave the previous read result in place (no write-through).
    always_comb begin
        dataout_d = dataout_q;
        if (readEn) begin
            dataout_d = readData;
        end
    end

    // Output register, cleared asynchronously alongside the array.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dataout_q <= '0;
        end else begin
            dataout_q <= dataout_d;
        end
    end

    assign dataout = dataout_q;

endmodule : sram_rw

// File: tb/tb_sram_rw.sv
// Self-checking bench for sram_rw: directed scenarios plus a random
// read/write mix, all compared against a simple array-and-register model.
module tb_sram_rw;
    import sram_pkg::*;

    logic       clk;
    logic       rst;
    logic       rw;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] dataout;

    word_t modelMem [DEPTH];
    word_t modelOut;

    int vectors;
    int miscompares;

    sram_rw #(
        .DATA_W (8),
        .ADDR_W (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rw      (rw),
        .addr    (addr),
        .din     (din),
        .dataout (dataout)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model reset: every word and the output go to zero.
    task automatic modelClear();
        for (int i = 0; i < DEPTH; i++) modelMem[i] = '0;
        modelOut = '0;
    endtask

    // Called at a falling edge: drive one operation, let the rising edge
    // take it, update the model, and return at the next falling edge.
    task automatic applyStimulus(input logic opRw, input logic [3:0] a, input logic [7:0] d);
        rw   = opRw;
        addr = a;
        din  = d;
        @(posedge clk);
        if (rst) begin
            if (opRw == RW_WRITE) modelMem[a] = d;
            else                  modelOut   = modelMem[a];
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        rw   = RW_READ;
        addr = '0;
        din  = '0;
        modelClear();
        #2;
        vectors++;
        if (dataout !== 8'h00) begin
            $display("[TB] FAIL reset_no_clock: got %h expected 00", dataout);
            miscompares++;
        end
        // Attempt a write while reset is held; it must be ignored.
        rw   = RW_WRITE;
        addr = 4'd2;
        din  = 8'hEE;
        @(posedge clk);
        @(negedge clk);
        rw = RW_READ;
        #2 rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(RW_READ, 4'(i), 8'h00);
            vectors++;
            if (dataout !== 8'h00) begin
                $display("[TB] FAIL reset_read_addr%0d: got %h expected 00", i, dataout);
                miscompares++;
            end
        end
    endtask

    task automatic test_write_read();
        applyStimulus(RW_WRITE, 4'd3, 8'hA5);
        applyStimulus(RW_READ, 4'd3, 8'h00);
        vectors++;
        if (dataout !== 8'hA5) begin
            $display("[TB] FAIL write_then_read: got %h expected a5", dataout);
            miscompares++;
        end
    endtask

    task automatic test_write_holds();
        applyStimulus(RW_READ, 4'd3, 8'h00);
        applyStimulus(RW_WRITE, 4'd7, 8'h3C);
        vectors++;
        if (dataout !== 8'hA5) begin
            $display("[TB] FAIL write_holds_output: got %h expected a5", dataout);
            miscompares++;
        end
        applyStimulus(RW_READ, 4'd7, 8'h00);
        vectors++;
        if (dataout !== 8'h3C) begin
            $display("[TB] FAIL read_after_hold: got %h expected 3c", dataout);
            miscompares++;
        end
    endtask

    task automatic test_full_sweep();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(RW_WRITE, 4'(i), 8'(i) ^ 8'h5A);
        end
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(RW_READ, 4'(i), 8'h00);
            vectors++;
            if (dataout !== (8'(i) ^ 8'h5A)) begin
                $display("[TB] FAIL sweep_addr%0d: got %h expected %h", i, dataout, 8'(i) ^ 8'h5A);
                miscompares++;
            end
        end
        vectors++;
        if (dataout !== 8'h55) begin
            $display("[TB] FAIL sweep_top_word: got %h expected 55", dataout);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        applyStimulus(RW_WRITE, 4'd9, 8'h11);
        applyStimulus(RW_WRITE, 4'd9, 8'h22);
        applyStimulus(RW_READ, 4'd9, 8'h00);
        vectors++;
        if (dataout !== 8'h22) begin
            $display("[TB] FAIL overwrite_last_wins: got %h expected 22", dataout);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid_run();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(RW_WRITE, 4'(i), 8'(8'hC0 + i));
        end
        applyStimulus(RW_READ, 4'd4, 8'h00);
        vectors++;
        if (dataout !== 8'hC4) begin
            $display("[TB] FAIL pre_reset_read: got %h expected c4", dataout);
            miscompares++;
        end
        #2 rst = 1'b0;
        modelClear();
        #1;
        vectors++;
        if (dataout !== 8'h00) begin
            $display("[TB] FAIL mid_reset_async: got %h expected 00", dataout);
            miscompares++;
        end
        rw   = RW_WRITE;
        addr = 4'd5;
        din  = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (dataout !== 8'h00) begin
            $display("[TB] FAIL mid_reset_held: got %h expected 00", dataout);
            miscompares++;
        end
        rw   = RW_READ;
        addr = 4'd0;
        #2 rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(RW_READ, 4'(i), 8'h00);
            vectors++;
            if (dataout !== 8'h00) begin
                $display("[TB] FAIL mid_reset_read_addr%0d: got %h expected 00", i, dataout);
                miscompares++;
            end
        end
    endtask

    task automatic test_random();
        logic       opRw;
        logic [3:0] a;
        logic [7:0] d;
        for (int n = 0; n < 400; n++) begin
            opRw = 1'($urandom_range(0, 1));
            a    = 4'($urandom_range(0, DEPTH - 1));
            d    = 8'($urandom);
            applyStimulus(opRw, a, d);
            vectors++;
            if (dataout !== modelOut) begin
                $display("[TB] FAIL random_op%0d rw=%0b addr=%0d: got %h expected %h",
                         n, opRw, a, dataout, modelOut);
                miscompares++;
            end
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_write_read();
        test_write_holds();
        test_full_sweep();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_sram_rw
